// File: rtl/axi_lite_cfg_pkg.sv
// Shared constants and helpers for the AXI-Lite configuration slave.
// Response codes, status register layout, address decode and byte-lane merge.
package axi_lite_cfg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [7:0] STATUS_ADDR = 8'h80;

    localparam int ST_BUSY    = 0;
    localparam int ST_DONE    = 1;
    localparam int ST_OVERRUN = 2;

    typedef enum logic [1:0] {
        DEC_CFG    = 2'd0,
        DEC_STATUS = 2'd1,
        DEC_ERR    = 2'd2
    } dec_e;

    // Word index is addr[7:2]; everything else in the address is ignored.
    function automatic dec_e decode_addr(input logic [5:0] idx, input logic [5:0] last_idx);
        dec_e d;
        if (idx <= last_idx) begin
            d = DEC_CFG;
        end else if (idx == STATUS_ADDR[7:2]) begin
            d = DEC_STATUS;
        end else begin
            d = DEC_ERR;
        end
        return d;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_skid1.sv
// One-entry valid/ready holding buffer: ready while empty, cleared by pop_i.
module axi_lite_skid1 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [W-1:0] data_i,
    input  logic         pop_i,
    output logic         full_o,
    output logic [W-1:0] data_o
);

    logic         full_q, full_d;
    logic [W-1:0] data_q, data_d;

    // Load on handshake, drain on pop; the two are exclusive since ready means empty.
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        if (valid_i && !full_q) begin
            full_d = 1'b1;
            data_d = data_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end else begin
            full_d = full_q;
        end
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end

    assign ready_o = ~full_q;
    assign full_o  = full_q;
    assign data_o  = data_q;

endmodule

// File: rtl/axi_lite_cfg_slave.sv
// AXI-Lite config register file driving a wide payload, engine start pulse and status/IRQ.
// Optional macro AXI_LITE_CFG_READBACK_EN enables read-back of the config registers.
module axi_lite_cfg_slave
    import axi_lite_cfg_pkg::*;
#(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 32,
    parameter int REGISTER_NUMBER = 14
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_axi_awvalid,
    output logic                    s_axi_awready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]              s_axi_awprot,
    input  logic                    s_axi_wvalid,
    output logic                    s_axi_wready,
    input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                    s_axi_bvalid,
    input  logic                    s_axi_bready,
    output logic [1:0]              s_axi_bresp,
    input  logic                    s_axi_arvalid,
    output logic                    s_axi_arready,
    input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]              s_axi_arprot,
    output logic                    s_axi_rvalid,
    input  logic                    s_axi_rready,
    output logic [DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]              s_axi_rresp,
    output logic [1023:0]           payload,
    output logic                    engine_start,
    input  logic                    engine_done,
    output logic                    interrupt_req
);

    localparam logic [5:0] LAST_IDX = 6'(REGISTER_NUMBER);
    localparam int         WB_W     = DATA_WIDTH + DATA_WIDTH/8;

    logic                  aw_full_s, w_full_s, commit_s, trig_s;
    logic [7:0]            aw_addr_s;
    logic [WB_W-1:0]       w_buf_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic [3:0]            wstrb_s;
    logic [5:0]            w_idx_s, r_idx_s;
    dec_e                  w_dec_s, r_dec_s;

    logic [31:0] regs_q [REGISTER_NUMBER+1];
    logic        busy_q, done_q, ovr_q, start_q;
    logic        busy_d, done_d, ovr_d, start_d, busy_mid_s, done_clr_s, ovr_clr_s;
    logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d, ar_hs_s;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d, rresp_n_s;
    logic [31:0] rdata_q, rdata_d, rdata_n_s, rd_cfg_s, status_s;

    axi_lite_skid1 #(.W(8)) u_aw_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (s_axi_awvalid),
        .ready_o (s_axi_awready),
        .data_i  (s_axi_awaddr[7:0]),
        .pop_i   (commit_s),
        .full_o  (aw_full_s),
        .data_o  (aw_addr_s)
    );

    axi_lite_skid1 #(.W(WB_W)) u_w_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (s_axi_wvalid),
        .ready_o (s_axi_wready),
        .data_i  ({s_axi_wstrb, s_axi_wdata}),
        .pop_i   (commit_s),
        .full_o  (w_full_s),
        .data_o  (w_buf_s)
    );

    assign wdata_s  = w_buf_s[DATA_WIDTH-1:0];
    assign wstrb_s  = w_buf_s[WB_W-1 -: 4];
    assign w_idx_s  = aw_addr_s[7:2];
    assign w_dec_s  = decode_addr(w_idx_s, LAST_IDX);
    assign commit_s = aw_full_s && w_full_s && (!bvalid_q || s_axi_bready);
    assign trig_s   = commit_s && (w_dec_s == DEC_CFG) && (w_idx_s == LAST_IDX);

    // Config register file, byte-lane updates on commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= REGISTER_NUMBER; k++) regs_q[k] <= 32'd0;
        end else if (commit_s && (w_dec_s == DEC_CFG)) begin
            for (int k = 0; k <= REGISTER_NUMBER; k++) begin
                if (w_idx_s == 6'(k)) regs_q[k] <= merge_bytes(regs_q[k], wdata_s, wstrb_s);
            end
        end
    end

    // engine_done is applied before the trigger so a same-cycle trigger still starts.
    assign done_clr_s = commit_s && (w_dec_s == DEC_STATUS) && wstrb_s[0] && wdata_s[ST_DONE];
    assign ovr_clr_s  = commit_s && (w_dec_s == DEC_STATUS) && wstrb_s[0] && wdata_s[ST_OVERRUN];
    assign busy_mid_s = busy_q & ~engine_done;
    assign start_d    = trig_s & ~busy_mid_s;
    assign busy_d     = busy_mid_s | start_d;
    assign done_d     = (done_q & ~done_clr_s) | engine_done;
    assign ovr_d      = (ovr_q & ~ovr_clr_s) | (trig_s & busy_mid_s);

    assign bvalid_d = commit_s ? 1'b1 : (s_axi_bready ? 1'b0 : bvalid_q);
    assign bresp_d  = commit_s ? ((w_dec_s == DEC_ERR) ? RESP_SLVERR : RESP_OKAY) : bresp_q;

    assign r_idx_s = s_axi_araddr[7:2];
    assign r_dec_s = decode_addr(r_idx_s, LAST_IDX);
    assign ar_hs_s = s_axi_arvalid && !rvalid_q;

`ifdef AXI_LITE_CFG_READBACK_EN
    // Config read-back mux.
    always_comb begin
        rd_cfg_s = 32'd0;
        for (int k = 0; k <= REGISTER_NUMBER; k++) begin
            rd_cfg_s = (r_idx_s == 6'(k)) ? regs_q[k] : rd_cfg_s;
        end
    end
`else
    assign rd_cfg_s = 32'd0;
`endif

    // Status word and read response selection.
    always_comb begin
        status_s             = 32'd0;
        status_s[ST_BUSY]    = busy_q;
        status_s[ST_DONE]    = done_q;
        status_s[ST_OVERRUN] = ovr_q;
        case (r_dec_s)
            DEC_CFG: begin
                rdata_n_s = rd_cfg_s;
                rresp_n_s = RESP_OKAY;
            end
            DEC_STATUS: begin
                rdata_n_s = status_s;
                rresp_n_s = RESP_OKAY;
            end
            default: begin
                rdata_n_s = 32'd0;
                rresp_n_s = RESP_SLVERR;
            end
        endcase
    end

    assign rvalid_d = ar_hs_s ? 1'b1 : (s_axi_rready ? 1'b0 : rvalid_q);
    assign rdata_d  = ar_hs_s ? rdata_n_s : rdata_q;
    assign rresp_d  = ar_hs_s ? rresp_n_s : rresp_q;

    // Status, start pulse and AXI response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            start_q  <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= RESP_OKAY;
            rdata_q  <= 32'd0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            start_q  <= start_d;
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
        end
    end

    // Flatten the register file onto the payload bus.
    always_comb begin
        payload = '0;
        for (int k = 0; k <= REGISTER_NUMBER; k++) payload[32*k +: 32] = regs_q[k];
    end

    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = ~rvalid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign engine_start  = start_q;
    assign interrupt_req = done_q;

    wire unused_s = ^{s_axi_awprot, s_axi_arprot, aw_addr_s[1:0], s_axi_araddr[1:0],
                      s_axi_awaddr[ADDR_WIDTH-1:8], s_axi_araddr[ADDR_WIDTH-1:8]};

endmodule

// File: tb/tb_axi_lite_cfg_slave.sv
// Self-checking bench for axi_lite_cfg_slave: directed scenarios plus random traffic
// compared against a register-level reference model.
module tb_axi_lite_cfg_slave;

    localparam int NREG = 15;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_axi_awvalid = 1'b0, s_axi_awready;
    logic [31:0]   s_axi_awaddr = 32'd0;
    logic [2:0]    s_axi_awprot = 3'd0;
    logic          s_axi_wvalid = 1'b0, s_axi_wready;
    logic [31:0]   s_axi_wdata = 32'd0;
    logic [3:0]    s_axi_wstrb = 4'd0;
    logic          s_axi_bvalid, s_axi_bready = 1'b1;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_arvalid = 1'b0, s_axi_arready;
    logic [31:0]   s_axi_araddr = 32'd0;
    logic [2:0]    s_axi_arprot = 3'd0;
    logic          s_axi_rvalid, s_axi_rready = 1'b1;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic [1023:0] payload;
    logic          engine_start, engine_done = 1'b0, interrupt_req;

    axi_lite_cfg_slave dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .payload(payload), .engine_start(engine_start),
        .engine_done(engine_done), .interrupt_req(interrupt_req)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int start_cnt = 0;
    int b_cnt = 0;

    // Event counters sampled at the active edge (pre-update values = handshakes/pulses).
    always @(posedge clk) begin
        if (engine_start) start_cnt <= start_cnt + 1;
        if (s_axi_bvalid && s_axi_bready) b_cnt <= b_cnt + 1;
    end

    // Reference model: register contents and status flags.
    logic [31:0] m_regs [NREG];
    bit          m_busy, m_done, m_ovr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREG; k++) m_regs[k] = 32'd0;
        m_busy = 1'b0; m_done = 1'b0; m_ovr = 1'b0;
    endtask

    task automatic model_done();
        m_busy = 1'b0;
        m_done = 1'b1;
    endtask

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input bit done_first,
                               output logic [1:0] resp, output bit start);
        int idx;
        idx = int'(addr[7:2]);
        start = 1'b0;
        if (done_first) model_done();
        if (idx < NREG) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) m_regs[idx][8*b +: 8] = data[8*b +: 8];
            if (idx == NREG - 1) begin
                if (m_busy) m_ovr = 1'b1;
                else begin m_busy = 1'b1; start = 1'b1; end
            end
            resp = 2'b00;
        end else if (idx == 32) begin
            if (strb[0] && data[1]) m_done = 1'b0;
            if (strb[0] && data[2]) m_ovr = 1'b0;
            resp = 2'b00;
        end else begin
            resp = 2'b10;
        end
    endtask

    task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                              output logic [1:0] resp);
        int idx;
        idx = int'(addr[7:2]);
        if (idx < NREG) begin
`ifdef AXI_LITE_CFG_READBACK_EN
            data = m_regs[idx];
`else
            data = 32'd0;
`endif
            resp = 2'b00;
        end else if (idx == 32) begin
            data = {29'd0, m_ovr, m_done, m_busy};
            resp = 2'b00;
        end else begin
            data = 32'd0;
            resp = 2'b10;
        end
    endtask

    task automatic check_payload(input string tag);
        for (int k = 0; k < 32; k++)
            check($sformatf("%s_reg%0d", tag, k), payload[32*k +: 32],
                  (k < NREG) ? m_regs[k] : 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, 32'(s_axi_awready), 32'd1);
        check({tag, "_wready"},  32'(s_axi_wready),  32'd1);
        check({tag, "_arready"}, 32'(s_axi_arready), 32'd1);
        check({tag, "_bvalid"},  32'(s_axi_bvalid),  32'd0);
        check({tag, "_rvalid"},  32'(s_axi_rvalid),  32'd0);
        check({tag, "_bresp"},   32'(s_axi_bresp),   32'd0);
        check({tag, "_rresp"},   32'(s_axi_rresp),   32'd0);
        check({tag, "_rdata"},   s_axi_rdata,        32'd0);
        check({tag, "_start"},   32'(engine_start),  32'd0);
        check({tag, "_irq"},     32'(interrupt_req), 32'd0);
        check({tag, "_payload"}, 32'(|payload),      32'd0);
    endtask

    // Full write with AW and W presented together; optional engine_done in the commit cycle.
    task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input bit done_first, input bit chk_lat);
        bit aw_hs, w_hs, start_seen, exp_start;
        int n, lat;
        logic [1:0] resp, exp_resp;
        @(negedge clk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = data; s_axi_wstrb = strb;
        n = 0;
        while ((s_axi_awvalid || s_axi_wvalid) && n < 20) begin
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            @(negedge clk);
            if (aw_hs) s_axi_awvalid = 1'b0;
            if (w_hs)  s_axi_wvalid  = 1'b0;
            n++;
        end
        check({tag, "_accept"}, 32'(n < 20), 32'd1);
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        engine_done = done_first;
        lat = 0;
        while (!s_axi_bvalid && lat < 20) begin
            @(negedge clk);
            engine_done = 1'b0;
            lat++;
        end
        engine_done = 1'b0;
        check({tag, "_bvalid"}, 32'(s_axi_bvalid), 32'd1);
        resp = s_axi_bresp;
        start_seen = engine_start;
        model_write(addr, data, strb, done_first, exp_resp, exp_start);
        check({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
        check({tag, "_start"}, 32'(start_seen), 32'(exp_start));
        if (chk_lat) check({tag, "_lat"}, lat, 32'd1);
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, output logic [31:0] data);
        bit hs;
        int n;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        @(negedge clk);
        s_axi_arvalid = 1'b1; s_axi_araddr = addr;
        n = 0;
        while (s_axi_arvalid && n < 20) begin
            hs = s_axi_arready;
            @(negedge clk);
            if (hs) s_axi_arvalid = 1'b0;
            n++;
        end
        s_axi_arvalid = 1'b0;
        while (!s_axi_rvalid && n < 40) begin @(negedge clk); n++; end
        check({tag, "_rvalid"}, 32'(s_axi_rvalid), 32'd1);
        data = s_axi_rdata;
        model_read(addr, exp_data, exp_resp);
        check({tag, "_rdata"}, data, exp_data);
        check({tag, "_rresp"}, 32'(s_axi_rresp), 32'(exp_resp));
    endtask

    task automatic pulse_done();
        @(negedge clk); engine_done = 1'b1;
        @(negedge clk); engine_done = 1'b0;
        model_done();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rdv, addr, data, d1, d2;
        int b0, s0, op, r;

        model_reset();
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_in");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_out");

        // Sequential writes of all config registers; last one triggers.
        s0 = start_cnt;
        for (int k = 0; k < NREG; k++)
            wr($sformatf("seq%0d", k), 32'(4*k), 32'h11111111 + 32'(k), 4'hF, 1'b0, 1'b1);
        @(negedge clk);
        check("seq_start_cnt", start_cnt - s0, 32'd1);
        check_payload("seq");
        rd("st_busy", 32'h80, rdv);
        check("st_busy_val", rdv, 32'h1);
        pulse_done();
        check("irq_set", 32'(interrupt_req), 32'd1);
        rd("st_done", 32'h80, rdv);
        wr("w1c", 32'h80, 32'h6, 4'hF, 1'b0, 1'b0);
        rd("st_clr", 32'h80, rdv);
        check("irq_clr", 32'(interrupt_req), 32'd0);

        // Back-pressure: W leads AW, bready held low.
        s_axi_bready = 1'b0;
        b0 = b_cnt;
        d1 = $urandom; d2 = $urandom;
        @(negedge clk); s_axi_wvalid = 1'b1; s_axi_wdata = d1; s_axi_wstrb = 4'hF;
        @(negedge clk); s_axi_wvalid = 1'b0;
        repeat (2) @(negedge clk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0C;
        @(negedge clk); s_axi_awvalid = 1'b0;
        @(negedge clk);
        check("bp_bvalid1", 32'(s_axi_bvalid), 32'd1);
        check("bp_awready_free", 32'(s_axi_awready), 32'd1);
        model_write(32'h0C, d1, 4'hF, 1'b0, op[1:0], r[0]);
        check("bp_reg3", payload[32*3 +: 32], m_regs[3]);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h10;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = d2;
        @(negedge clk); s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("bp_awready_full", 32'(s_axi_awready), 32'd0);
        check("bp_wready_full",  32'(s_axi_wready),  32'd0);
        @(negedge clk);
        check("bp_hold_bvalid", 32'(s_axi_bvalid), 32'd1);
        check("bp_hold_awready", 32'(s_axi_awready), 32'd0);
        check("bp_reg4_old", payload[32*4 +: 32], m_regs[4]);
        s_axi_bready = 1'b1;
        repeat (3) @(negedge clk);
        check("bp_resp_cnt", b_cnt - b0, 32'd2);
        check("bp_bvalid_end", 32'(s_axi_bvalid), 32'd0);
        check("bp_ready_end", 32'({s_axi_awready, s_axi_wready}), 32'd3);
        model_write(32'h10, d2, 4'hF, 1'b0, op[1:0], r[0]);
        check_payload("bp");

        // Partial strobe.
        wr("ps_zero", 32'h14, 32'h0, 4'hF, 1'b0, 1'b0);
        wr("ps", 32'h14, 32'hAABBCCDD, 4'b0101, 1'b0, 1'b0);
        check("ps_payload", payload[32*5 +: 32], 32'h00BB00DD);
        rd("ps_rd", 32'h14, rdv);

        // Out-of-range, trigger while busy, W1C.
        wr("oor", 32'h40, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0);
        check_payload("oor");
        rd("oor_rd", 32'h40, rdv);
        wr("trig1", 32'h38, 32'h1, 4'hF, 1'b0, 1'b0);
        wr("trig_busy", 32'h38, 32'h2, 4'hF, 1'b0, 1'b0);
        rd("st5", 32'h80, rdv);
        check("st5_val", rdv, 32'h5);
        pulse_done();
        rd("st6", 32'h80, rdv);
        check("st6_val", rdv, 32'h6);
        check("st6_irq", 32'(interrupt_req), 32'd1);
        wr("w1c6", 32'h80, 32'h6, 4'hF, 1'b0, 1'b0);
        rd("st0", 32'h80, rdv);
        check("st0_val", rdv, 32'h0);
        check("st0_irq", 32'(interrupt_req), 32'd0);

        // Trigger commit coinciding with engine_done.
        wr("trig2", 32'h38, 32'h3, 4'hF, 1'b0, 1'b0);
        wr("trig_done", 32'h38, 32'h4, 4'hF, 1'b1, 1'b0);
        rd("st3", 32'h80, rdv);
        check("st3_val", rdv, 32'h3);

        // Reset pulsed with an address already buffered.
        @(negedge clk); s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h08;
        @(negedge clk); s_axi_awvalid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        wr("post_rst", 32'h08, 32'hCAFEF00D, 4'hF, 1'b0, 1'b1);
        check_payload("post_rst");
        wr("cfg0", 32'h00, 32'h12345678, 4'hF, 1'b0, 1'b0);
        rd("cfg0_rd", 32'h00, rdv);
        rd("cfg0_st", 32'h80, rdv);

        // Random traffic.
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 9));
            r  = int'($urandom_range(0, 20));
            if (r < NREG)       addr = {$urandom, 8'h00} | 32'(4*r) | 32'($urandom_range(0, 3));
            else if (r < 18)    addr = {$urandom, 8'h00} | 32'h80;
            else                addr = {$urandom, 8'h00} | 32'(8'h40 + 8'(4*$urandom_range(1, 15)));
            data = $urandom;
            if (op < 5)      wr($sformatf("rnd%0d_wr", i), addr, data, 4'($urandom), 1'b0, 1'b0);
            else if (op < 8) rd($sformatf("rnd%0d_rd", i), addr, rdv);
            else if (op < 9) pulse_done();
            else             @(negedge clk);
        end
        @(negedge clk);
        check_payload("rnd");
        check("rnd_irq", 32'(interrupt_req), 32'(m_done));
        rd("rnd_st", 32'h80, rdv);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
